xnor_serial_arbiter: RTL and testbench
======================================

// Module: xnor_serial_arbiter
//
// PURPOSE
//  Shares one gate-level XNOR cell (xnor_gatelevel_gate) between NREQ requesters.
//  Each requester asks for an equality compare of two WIDTH-bit words.
//  A round-robin scheduler grants one requester at a time. The block captures its
//  operands and streams them LSB-first through the shared XNOR, ANDing each bit result.
//  It then reports eq / done_id with a one-cycle done pulse.
//
// PARAMETERS
//  NREQ   4  number of requesters (>=2)
//  WIDTH  8  operand width in bits (>=1); also the number of SHIFT cycles
//
// PORTS
//  clk      in   1           rising-edge clock
//  rst_n    in   1           asynchronous active-low reset
//  req      in   NREQ        req[i]=1: requester i wants a compare; held until its done
//  a_bus    in   NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
//  b_bus    in   NREQ*WIDTH  operand B, same slicing
//  gnt      out  NREQ        one-hot grant; high while requester i is being serviced
//  busy     out  1           1 in SHIFT and REPORT
//  done     out  1           one-cycle pulse; eq/done_id valid
//  done_id  out  ID_W        index of the finished requester, ID_W=$clog2(NREQ)
//  eq       out  1           1 if A==B for the finished requester
//
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset (async, any state): state=IDLE, gnt=0, busy=0, done=0, done_id=0, eq=0,
//    rr pointer=0, shift regs=0, bit counter=0.
//  - IDLE:
//    - If no req is set: stay in IDLE, all outputs held.
//    - Else, at that edge: pick the first set req[i] scanning i = ptr, ptr+1, ...
//      mod NREQ. Capture a/b slices of the winner into shift regs, acc=1, cnt=0,
//      gnt=onehot(i), busy=1, cur_id=i, go to SHIFT.
//  - SHIFT, each edge:
//    - acc <= acc & xnor_out(a_sr[0], b_sr[0]); shift both regs right; cnt++.
//    - When cnt reaches WIDTH-1 (last bit processed): go to REPORT,
//      eq <= final acc, done <= 1, done_id <= cur_id.
//  - REPORT, one cycle, then at next edge:
//    - done <= 0, gnt <= 0, busy <= 0, ptr <= (cur_id+1) mod NREQ, go to IDLE.
//  - Timing: gnt rises edge k; done high after edge k+WIDTH; next grant no earlier than
//    edge k+WIDTH+2. Service period = WIDTH+2 cycles.
//  - Always full WIDTH cycles; no early exit on mismatch (deterministic latency).
//  - eq and done_id hold their value until the next done.
//  - Boundaries:
//    - req[i] dropped during SHIFT/REPORT: ignored; the compare completes.
//    - Operand changes after capture: ignored; the result uses the captured words.
//    - Simultaneous reqs: only the round-robin winner is granted.
//    - The requester just serviced is lowest priority next round.
//      It may re-request in REPORT and is served if alone.
//    - ptr wraps NREQ-1 -> 0.
//    - cnt is $clog2(WIDTH+1) bits and never exceeds WIDTH-1.
//    - Reset mid-SHIFT aborts with no done pulse; after release, requester 0 has top
//      priority.
//
// STRUCTURE
//  - Shared package xnor_sched_pkg:
//    - state encoding localparams S_IDLE=2'd0, S_SHIFT=2'd1, S_REPORT=2'd2.
//    - ID width helper.
//  - Sub-module rr_arbiter_pick: combinational (req, ptr) -> (any, winner_id); the only
//    new sub-module.
//  - The shared datapath is exactly one xnor_gatelevel_gate instance fed by a_sr[0],
//    b_sr[0].
//  - FSM, shift regs, counter and accumulator live in this module.
//
// TESTING (NREQ=4, WIDTH=8)
//  1. req=0001, A0=8'hA5, B0=8'hA5
//     -> gnt=0001 after 1 edge; done 8 cycles later, eq=1, done_id=0; gnt=0 next cycle.
//  2. req=0100, A2=8'hA5, B2=8'hA4 (LSB differs)
//     -> done with eq=0, done_id=2, still after the full 8 SHIFT cycles.
//  3. After reset, req=1111 held, all operands equal
//     -> done_id sequence 0,1,2,3,0; done pulses 10 cycles apart.
//  4. req=1010 held continuously -> grants alternate 1,3,1,3; never two in a row.
//  5. Assert rst_n=0 during SHIFT cycle 4
//     -> gnt=0, busy=0, done=0, eq=0 immediately; no done pulse; after release with
//        req=1111, id 0 is served first.
//  6. Grant req0 with A0=B0=8'h3C, change A0 to 8'h00 and drop req0 at SHIFT cycle 2
//     -> done, eq=1, done_id=0.

Source files
------------

// File: rtl/xnor_sched_pkg.sv
// ---------------------------------------------------------------------------
// xnor_sched_pkg
//   Shared definitions for the serial XNOR compare arbiter:
//   - state_t : FSM state encoding (IDLE / SHIFT / REPORT)
//   - id_width: width of a requester index for a given requester count
// ---------------------------------------------------------------------------
package xnor_sched_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_REPORT = 2'd2
   } state_t;

   // A single requester still needs a 1-bit index so that port widths stay legal.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter_pick.sv
// ---------------------------------------------------------------------------
// rr_arbiter_pick
//   Combinational round-robin pick. It scans req starting at index ptr and
//   wraps modulo NREQ. It returns the first set requester.
//   Ports:
//     req    : request vector
//     ptr    : highest-priority index for this scan
//     any    : at least one request is set
//     winner : index of the selected requester (0 when any=0)
// ---------------------------------------------------------------------------
module rr_arbiter_pick #(
   parameter int NREQ = 4,
   parameter int ID_W = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [ID_W-1:0] ptr,
   output logic            any,
   output logic [ID_W-1:0] winner
);

   // One extra bit so that ptr + offset cannot overflow before the wrap.
   logic [ID_W:0] idx_sum;

   always_comb begin
      // NOTE: every signal written here gets a default first so no latch is inferred.
      any     = 1'b0;
      winner  = '0;
      idx_sum = '0;
      // Scan from the farthest offset down to offset 0. The last hit is kept,
      // so the requester closest to ptr wins.
      for (int j = NREQ - 1; j >= 0; j--) begin
         idx_sum = {1'b0, ptr} + (ID_W + 1)'(j);
         if (idx_sum >= (ID_W + 1)'(NREQ)) begin
            idx_sum = idx_sum - (ID_W + 1)'(NREQ);
         end
         if (req[idx_sum[ID_W-1:0]]) begin
            any    = 1'b1;
            winner = idx_sum[ID_W-1:0];
         end
      end
   end

endmodule

// File: rtl/xnor_gatelevel_gate.sv
// ---------------------------------------------------------------------------
// xnor_gatelevel_gate
//   Single gate-level XNOR cell. It is the one compare resource shared by all
//   requesters of xnor_serial_arbiter.
//   Ports:
//     a, b : input bits
//     y    : a XNOR b
// ---------------------------------------------------------------------------
module xnor_gatelevel_gate (
   input  logic a,
   input  logic b,
   output logic y
);

   xnor u_xnor (y, a, b);

endmodule

// File: rtl/xnor_serial_arbiter.sv
// ---------------------------------------------------------------------------
// xnor_serial_arbiter
//   Shares one gate-level XNOR cell between NREQ requesters. Each requester
//   asks for an equality compare of two WIDTH-bit words. A round-robin winner
//   has its operands captured. The operands then stream LSB-first through the
//   XNOR, and the bit results are ANDed together. The result is reported with
//   a one-cycle done pulse. Every compare takes exactly WIDTH shift cycles.
//   Ports:
//     clk     : rising-edge clock
//     rst_n   : asynchronous active-low reset
//     req     : req[i]=1 requests a compare for requester i
//     a_bus   : operand A, requester i at [i*WIDTH +: WIDTH]
//     b_bus   : operand B, same slicing
//     gnt     : one-hot grant, high while requester i is serviced
//     busy    : high in SHIFT and REPORT
//     done    : one-cycle pulse; eq / done_id valid
//     done_id : index of the finished requester
//     eq      : 1 when A == B for the finished requester
// ---------------------------------------------------------------------------
module xnor_serial_arbiter
   import xnor_sched_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NREQ-1:0]               req,
   input  logic [NREQ*WIDTH-1:0]         a_bus,
   input  logic [NREQ*WIDTH-1:0]         b_bus,
   output logic [NREQ-1:0]               gnt,
   output logic                          busy,
   output logic                          done,
   output logic [id_width(NREQ)-1:0]     done_id,
   output logic                          eq
);

   localparam int ID_W  = id_width(NREQ);
   localparam int CNT_W = $clog2(WIDTH + 1);

   state_t            state;
   logic [ID_W-1:0]   ptr;
   logic [ID_W-1:0]   cur_id;
   logic [WIDTH-1:0]  a_sr;
   logic [WIDTH-1:0]  b_sr;
   logic [CNT_W-1:0]  cnt;
   logic              acc;

   logic              pick_any;
   logic [ID_W-1:0]   pick_id;
   logic [NREQ-1:0]   pick_onehot;
   logic              bit_eq;

   // Per-requester operand views, so the winner's words can be selected by index.
   logic [WIDTH-1:0]  a_arr [NREQ];
   logic [WIDTH-1:0]  b_arr [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_slice
      assign a_arr[i] = a_bus[i*WIDTH +: WIDTH];
      assign b_arr[i] = b_bus[i*WIDTH +: WIDTH];
   end

   rr_arbiter_pick #(
      .NREQ (NREQ),
      .ID_W (ID_W)
   ) u_pick (
      .req    (req),
      .ptr    (ptr),
      .any    (pick_any),
      .winner (pick_id)
   );

   assign pick_onehot = NREQ'(1) << pick_id;

   // The single shared compare cell sees only the current LSBs.
   xnor_gatelevel_gate u_xnor_cell (
      .a (a_sr[0]),
      .b (b_sr[0]),
      .y (bit_eq)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         ptr     <= '0;
         cur_id  <= '0;
         a_sr    <= '0;
         b_sr    <= '0;
         cnt     <= '0;
         acc     <= 1'b0;
         gnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         done_id <= '0;
         eq      <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignments. All reads in this
         // block therefore see values from before the edge.
         case (state)
            S_IDLE: begin
               if (pick_any) begin
                  a_sr   <= a_arr[pick_id];
                  b_sr   <= b_arr[pick_id];
                  acc    <= 1'b1;
                  cnt    <= '0;
                  gnt    <= pick_onehot;
                  busy   <= 1'b1;
                  cur_id <= pick_id;
                  state  <= S_SHIFT;
               end
            end

            S_SHIFT: begin
               acc  <= acc & bit_eq;
               a_sr <= a_sr >> 1;
               b_sr <= b_sr >> 1;
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  // The last bit is folded in directly. This keeps the
                  // latency at exactly WIDTH cycles.
                  eq      <= acc & bit_eq;
                  done    <= 1'b1;
                  done_id <= cur_id;
                  state   <= S_REPORT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_REPORT: begin
               done  <= 1'b0;
               gnt   <= '0;
               busy  <= 1'b0;
               // The requester just served becomes lowest priority.
               ptr   <= (cur_id == ID_W'(NREQ - 1)) ? '0 : cur_id + 1'b1;
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_xnor_serial_arbiter.sv
// ---------------------------------------------------------------------------
// tb_xnor_serial_arbiter
//   Directed bench for xnor_serial_arbiter with NREQ=4, WIDTH=8. A vector
//   table covers single-requester compares. Hand-written sequences cover
//   round-robin order, reset during SHIFT, and operand or request changes
//   after capture.
// ---------------------------------------------------------------------------
module tb_xnor_serial_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] a_bus;
   logic [NREQ*WIDTH-1:0] b_bus;
   logic [NREQ-1:0]       gnt;
   logic                  busy;
   logic                  done;
   logic [1:0]            done_id;
   logic                  eq;

   int n_cmp = 0;
   int n_bad = 0;

   xnor_serial_arbiter #(
      .NREQ  (NREQ),
      .WIDTH (WIDTH)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .a_bus   (a_bus),
      .b_bus   (b_bus),
      .gnt     (gnt),
      .busy    (busy),
      .done    (done),
      .done_id (done_id),
      .eq      (eq)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] a;
      logic [7:0] b;
      logic       exp_eq;
   } vec_t;

   vec_t vecs [7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic set_ops(input int id, input logic [7:0] a, input logic [7:0] b);
      a_bus[id*WIDTH +: WIDTH] = a;
      b_bus[id*WIDTH +: WIDTH] = b;
   endtask

   // Ticks until done is seen or the budget runs out. The caller checks cyc.
   task automatic wait_done(output int cyc);
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (done !== 1'b1 && cyc < 30);
      check("done_seen", 32'(done), 32'd1);
   endtask

   int cyc;
   logic [1:0] exp_ids3 [5];
   logic [1:0] exp_ids4 [4];
   logic [1:0] prev_id;

   initial begin
      vecs[0] = '{id: 2'd0, a: 8'hA5, b: 8'hA5, exp_eq: 1'b1};
      vecs[1] = '{id: 2'd2, a: 8'hA5, b: 8'hA4, exp_eq: 1'b0};  // LSB differs
      vecs[2] = '{id: 2'd1, a: 8'hFF, b: 8'hFF, exp_eq: 1'b1};
      vecs[3] = '{id: 2'd3, a: 8'h00, b: 8'h80, exp_eq: 1'b0};  // MSB differs
      vecs[4] = '{id: 2'd3, a: 8'h5A, b: 8'h5A, exp_eq: 1'b1};
      vecs[5] = '{id: 2'd1, a: 8'h00, b: 8'h00, exp_eq: 1'b1};
      vecs[6] = '{id: 2'd0, a: 8'h10, b: 8'h00, exp_eq: 1'b0};  // middle bit differs
      exp_ids3 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      exp_ids4 = '{2'd1, 2'd3, 2'd1, 2'd3};

      req   = '0;
      a_bus = '0;
      b_bus = '0;
      rst_n = 1'b0;
      tick();
      tick();
      check("rst_gnt",     32'(gnt),     32'd0);
      check("rst_busy",    32'(busy),    32'd0);
      check("rst_done",    32'(done),    32'd0);
      check("rst_done_id", 32'(done_id), 32'd0);
      check("rst_eq",      32'(eq),      32'd0);
      rst_n = 1'b1;
      tick();
      check("idle_no_req_busy", 32'(busy), 32'd0);

      // Single-requester compares from the vector table.
      for (int i = 0; i < 7; i++) begin
         for (int j = 0; j < NREQ; j++) begin
            // Other slices get the opposite outcome, so a wrong selection is visible.
            set_ops(j, 8'hC3, vecs[i].exp_eq ? 8'h3C : 8'hC3);
         end
         set_ops(int'(vecs[i].id), vecs[i].a, vecs[i].b);
         req = 4'(1 << vecs[i].id);
         tick();
         check("vec_gnt",  32'(gnt),  32'(1 << vecs[i].id));
         check("vec_busy", 32'(busy), 32'd1);
         wait_done(cyc);
         check("vec_latency", 32'(cyc),     32'd8);
         check("vec_eq",      32'(eq),      32'(vecs[i].exp_eq));
         check("vec_done_id", 32'(done_id), 32'(vecs[i].id));
         req = '0;
         tick();
         check("vec_done_pulse", 32'(done),    32'd0);
         check("vec_gnt_clear",  32'(gnt),     32'd0);
         check("vec_busy_clear", 32'(busy),    32'd0);
         check("vec_eq_hold",    32'(eq),      32'(vecs[i].exp_eq));
         check("vec_id_hold",    32'(done_id), 32'(vecs[i].id));
      end

      // All four requesting after reset: 0,1,2,3,0 with a 10-cycle period.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      a_bus = 32'h1234_5678;
      b_bus = 32'h1234_5678;
      req   = 4'hF;
      for (int k = 0; k < 5; k++) begin
         wait_done(cyc);
         check("rr4_period",  32'(cyc),     (k == 0) ? 32'd9 : 32'd10);
         check("rr4_done_id", 32'(done_id), 32'(exp_ids3[k]));
         check("rr4_eq",      32'(eq),      32'd1);
      end

      // Two requesters held: grants alternate 1,3,1,3 and never repeat.
      req = 4'b1010;
      prev_id = 2'd0;
      for (int k = 0; k < 4; k++) begin
         wait_done(cyc);
         check("alt_period",  32'(cyc),     32'd10);
         check("alt_done_id", 32'(done_id), 32'(exp_ids4[k]));
         if (k > 0) check("alt_no_repeat", 32'(done_id != prev_id), 32'd1);
         prev_id = done_id;
      end

      // Reset during SHIFT cycle 4 aborts with no done pulse.
      req = '0;
      tick();
      req = 4'b0100;
      tick();
      check("abort_gnt", 32'(gnt), 32'b0100);
      repeat (4) tick();
      check("abort_busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_gnt_rst",     32'(gnt),     32'd0);
      check("abort_busy_rst",    32'(busy),    32'd0);
      check("abort_done_rst",    32'(done),    32'd0);
      check("abort_eq_rst",      32'(eq),      32'd0);
      check("abort_done_id_rst", 32'(done_id), 32'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("abort_no_done", 32'(done), 32'd0);
      end
      rst_n = 1'b1;
      req   = 4'hF;
      wait_done(cyc);
      check("post_rst_latency", 32'(cyc),     32'd9);
      check("post_rst_first",   32'(done_id), 32'd0);

      // Requester 0 re-requests alone in REPORT. Its operand and request
      // change after capture, and the captured words must decide the result.
      req = 4'b0001;
      set_ops(0, 8'h3C, 8'h3C);
      tick();
      tick();
      check("reuse_gnt", 32'(gnt), 32'b0001);
      tick();
      tick();
      set_ops(0, 8'h00, 8'h3C);
      req = '0;
      wait_done(cyc);
      check("late_change_latency", 32'(cyc),     32'd6);
      check("late_change_eq",      32'(eq),      32'd1);
      check("late_change_id",      32'(done_id), 32'd0);
      tick();
      tick();
      check("final_idle_busy", 32'(busy), 32'd0);
      check("final_idle_gnt",  32'(gnt),  32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
